// File: rtl/alien_march_ctrl_pkg.sv
// Shared types and default geometry for the invader formation march controller.
package alien_march_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, MARCH, LANDED} march_state_e;
  typedef enum logic {MOVE, DESCEND} step_kind_e;

  localparam int unsigned XW_DEF          = 10;
  localparam int unsigned YW_DEF          = 10;
  localparam int unsigned X_MIN_DEF       = 0;
  localparam int unsigned X_MAX_DEF       = 640;
  localparam int unsigned FORM_W_DEF      = 352;
  localparam int unsigned X_START_DEF     = 0;
  localparam int unsigned Y_START_DEF     = 64;
  localparam int unsigned X_STEP_DEF      = 8;
  localparam int unsigned Y_STEP_DEF      = 16;
  localparam int unsigned Y_LAND_DEF      = 400;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/alien_march_ctrl_toggle_sync.sv
// Synchronises the divided step clock and emits a one-cycle tick per transition,
// held off after reset until the chain has settled.
module alien_march_ctrl_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic tick_o
);

  localparam int unsigned PRIME = SYNC_STAGES + 1;
  localparam int unsigned CW    = $clog2(PRIME + 1);

  // One extra flop beyond the synchroniser holds the previous settled level.
  logic [SYNC_STAGES:0] sync_q;
  logic [CW-1:0]        prime_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], async_i};
      if (prime_q != CW'(PRIME)) prime_q <= prime_q + 1'b1;
    end
  end

  assign tick_o = (prime_q == CW'(PRIME)) && (sync_q[SYNC_STAGES] ^ sync_q[SYNC_STAGES-1]);

endmodule

// File: rtl/alien_march_ctrl.sv
// Invader formation march controller: one formation step per step_clk transition,
// row descent at the playfield edges, landing detection.
module alien_march_ctrl
  import alien_march_ctrl_pkg::*;
#(
  parameter int unsigned XW          = XW_DEF,
  parameter int unsigned YW          = YW_DEF,
  parameter int unsigned X_MIN       = X_MIN_DEF,
  parameter int unsigned X_MAX       = X_MAX_DEF,
  parameter int unsigned FORM_W      = FORM_W_DEF,
  parameter int unsigned X_START     = X_START_DEF,
  parameter int unsigned Y_START     = Y_START_DEF,
  parameter int unsigned X_STEP      = X_STEP_DEF,
  parameter int unsigned Y_STEP      = Y_STEP_DEF,
  parameter int unsigned Y_LAND      = Y_LAND_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          clk_rst,
  input  logic          step_clk,
  input  logic          enable,
  input  logic          restart,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          dir,
  output logic          anim_frame,
  output logic          step_pulse,
  output logic          landed
);

  localparam logic [XW:0]   X_STEP_E  = (XW+1)'(X_STEP);
  localparam logic [XW:0]   X_MIN_E   = (XW+1)'(X_MIN);
  localparam logic [XW:0]   X_MAX_E   = (XW+1)'(X_MAX);
  localparam logic [XW:0]   FORM_W_E  = (XW+1)'(FORM_W);
  localparam logic [YW:0]   Y_STEP_E  = (YW+1)'(Y_STEP);
  localparam logic [YW:0]   Y_LAND_E  = (YW+1)'(Y_LAND);
  localparam logic [XW-1:0] X_STEP_N  = XW'(X_STEP);
  localparam logic [XW-1:0] X_START_N = XW'(X_START);
  localparam logic [YW-1:0] Y_START_N = YW'(Y_START);

  march_state_e  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          dir_q, dir_d;
  logic          anim_q, anim_d;
  logic          pulse_q, pulse_d;

  logic          tick;
  logic          step_go;
  step_kind_e    kind;
  logic [XW:0]   x_ext;
  logic [YW:0]   y_sum;
  logic [YW-1:0] y_desc;
  logic          reach_land;

  alien_march_ctrl_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (clk_rst),
    .async_i(step_clk),
    .tick_o (tick)
  );

  // Edge tests run one bit wider than the offsets so they cannot wrap.
  always_comb begin
    x_ext  = {1'b0, x_q};
    y_sum  = {1'b0, y_q} + Y_STEP_E;
    y_desc = y_sum[YW] ? '1 : y_sum[YW-1:0];
    if (dir_q) kind = (x_ext + X_STEP_E + FORM_W_E <= X_MAX_E) ? MOVE : DESCEND;
    else       kind = (x_ext >= X_MIN_E + X_STEP_E) ? MOVE : DESCEND;
    reach_land = ({1'b0, y_desc} >= Y_LAND_E);
  end

  assign step_go = (state_q == MARCH) && tick && enable && !restart;

  always_ff @(posedge clk or posedge clk_rst) begin
    if (clk_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = MARCH;
        MARCH:   if (step_go && kind == DESCEND && reach_land) state_d = LANDED;
        LANDED:  state_d = LANDED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    anim_d  = anim_q;
    pulse_d = 1'b0;
    if (restart) begin
      x_d    = X_START_N;
      y_d    = Y_START_N;
      dir_d  = 1'b1;
      anim_d = 1'b0;
    end else if (step_go) begin
      pulse_d = 1'b1;
      anim_d  = ~anim_q;
      if (kind == MOVE) begin
        x_d = dir_q ? x_q + X_STEP_N : x_q - X_STEP_N;
      end else begin
        y_d   = y_desc;
        dir_d = ~dir_q;
      end
    end
  end

  always_ff @(posedge clk or posedge clk_rst) begin
    if (clk_rst) begin
      x_q     <= X_START_N;
      y_q     <= Y_START_N;
      dir_q   <= 1'b1;
      anim_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      anim_q  <= anim_d;
      pulse_q <= pulse_d;
    end
  end

  assign x_off      = x_q;
  assign y_off      = y_q;
  assign dir        = dir_q;
  assign anim_frame = anim_q;
  assign step_pulse = pulse_q;
  assign landed     = (state_q == LANDED);

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the formation.
module tb_alien_march_ctrl;

  localparam int unsigned XW = 10, YW = 10, X_MIN = 0, X_MAX = 64, FORM_W = 32;
  localparam int unsigned X_START = 0, Y_START = 0, X_STEP = 8, Y_STEP = 16;
  localparam int unsigned Y_LAND = 48, SS = 2;
  localparam int YMAXV = (1 << YW) - 1;

  logic          clk = 1'b0;
  logic          clk_rst = 1'b1;
  logic          step_clk = 1'b0;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic          dir, anim_frame, step_pulse, landed;

  alien_march_ctrl #(
    .XW(XW), .YW(YW), .X_MIN(X_MIN), .X_MAX(X_MAX), .FORM_W(FORM_W),
    .X_START(X_START), .Y_START(Y_START), .X_STEP(X_STEP), .Y_STEP(Y_STEP),
    .Y_LAND(Y_LAND), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .clk_rst(clk_rst), .step_clk(step_clk), .enable(enable),
    .restart(restart), .x_off(x_off), .y_off(y_off), .dir(dir),
    .anim_frame(anim_frame), .step_pulse(step_pulse), .landed(landed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0 = waiting, 1 = marching, 2 = landed.
  int m_x, m_y, m_dir, m_anim, m_pulse, m_mode, cyc;
  bit last_in;
  int due[$];

  always @(posedge clk or posedge clk_rst) begin
    bit tk;
    if (clk_rst) begin
      m_x = X_START; m_y = Y_START; m_dir = 1; m_anim = 0; m_pulse = 0; m_mode = 0;
      cyc = 0; last_in = 1'b0; due.delete();
    end else begin
      cyc++;
      tk = 1'b0;
      // A level change seen at edge k becomes a step at edge k+2.
      if (step_clk != last_in) begin
        due.push_back(cyc + 2);
        last_in = step_clk;
      end
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        tk = (cyc >= SS + 2);
      end
      m_pulse = 0;
      if (restart) begin
        m_x = X_START; m_y = Y_START; m_dir = 1; m_anim = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (enable) m_mode = 1;
      end else if (m_mode == 1 && tk && enable) begin
        m_pulse = 1;
        m_anim  = 1 - m_anim;
        if (m_dir == 1 && m_x + X_STEP + FORM_W <= X_MAX) m_x += X_STEP;
        else if (m_dir == 0 && m_x >= X_MIN + X_STEP)     m_x -= X_STEP;
        else begin
          m_y   = (m_y + Y_STEP > YMAXV) ? YMAXV : m_y + Y_STEP;
          m_dir = 1 - m_dir;
          if (m_y >= Y_LAND) m_mode = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("x_off", x_off, m_x);
      chk("y_off", y_off, m_y);
      chk("dir", dir, m_dir);
      chk("anim_frame", anim_frame, m_anim);
      chk("step_pulse", step_pulse, m_pulse);
      chk("landed", landed, (m_mode == 2) ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (step_pulse === 1'b1) pulses++;
  end

  task automatic do_reset(input bit sc, input bit en);
    @(negedge clk);
    #2 clk_rst = 1'b1;
    step_clk = sc; enable = en; restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clk_rst = 1'b0;
  endtask

  // Toggle step_clk, require silence for two cycles, then the step with literal values.
  task automatic step_watch(input int ex, input int ey, input int ed);
    @(negedge clk);
    step_clk = ~step_clk;
    @(negedge clk); chk("lat_quiet1", step_pulse, 0);
    @(negedge clk); chk("lat_quiet2", step_pulse, 0);
    @(negedge clk);
    chk("lat_pulse", step_pulse, 1);
    chk("lit_x", x_off, ex);
    chk("lit_y", y_off, ey);
    chk("lit_dir", dir, ed);
  endtask

  task automatic quiet_toggle();
    int p0;
    p0 = pulses;
    @(negedge clk);
    step_clk = ~step_clk;
    repeat (5) @(negedge clk);
    chk("no_step", pulses - p0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    clk_rst = 1'b0;
    chk("rst_x", x_off, X_START);
    chk("rst_y", y_off, Y_START);
    chk("rst_dir", dir, 1);
    chk("rst_landed", landed, 0);

    // Rightward march, edge descent, leftward march, landing.
    enable = 1'b1;
    repeat (5) @(negedge clk);
    p0 = pulses;
    step_watch(8, 0, 1);
    step_watch(16, 0, 1);
    step_watch(24, 0, 1);
    step_watch(32, 0, 1);
    step_watch(32, 16, 0);
    @(negedge clk);
    chk("five_pulses", pulses - p0, 5);
    step_watch(24, 16, 0);
    step_watch(16, 16, 0);
    step_watch(8, 16, 0);
    step_watch(0, 16, 0);
    step_watch(0, 32, 1);
    step_watch(8, 32, 1);
    step_watch(16, 32, 1);
    step_watch(24, 32, 1);
    step_watch(32, 32, 1);
    step_watch(32, 48, 0);
    chk("lit_landed", landed, 1);
    repeat (3) quiet_toggle();
    chk("landed_hold_y", y_off, 48);

    // step_clk high through reset release must not produce a step.
    do_reset(1'b1, 1'b1);
    p0 = pulses;
    repeat (8) @(negedge clk);
    chk("prime_pulses", pulses - p0, 0);
    chk("prime_x", x_off, 0);

    // Paused ticks are dropped, not queued.
    enable = 1'b0;
    p0 = pulses;
    repeat (3) begin
      @(negedge clk); step_clk = ~step_clk;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("pause_x", x_off, 0);
    chk("pause_pulses", pulses - p0, 0);
    step_watch(8, 0, 1);
    repeat (4) @(negedge clk);
    chk("pause_single", pulses - p0, 1);

    // Restart coinciding with a tick.
    step_watch(16, 0, 1);
    step_watch(24, 0, 1);
    @(negedge clk); step_clk = ~step_clk;
    @(negedge clk);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    chk("rs_x", x_off, 0);
    chk("rs_y", y_off, 0);
    chk("rs_dir", dir, 1);
    chk("rs_pulse", step_pulse, 0);
    chk("rs_anim", anim_frame, 0);

    // Asynchronous reset between edges mid-march.
    repeat (3) @(negedge clk);
    step_watch(8, 0, 1);
    step_watch(16, 0, 1);
    @(negedge clk);
    #2 clk_rst = 1'b1;
    #1;
    chk("arst_x", x_off, X_START);
    chk("arst_y", y_off, Y_START);
    chk("arst_dir", dir, 1);
    chk("arst_anim", anim_frame, 0);
    chk("arst_pulse", step_pulse, 0);
    @(negedge clk);
    clk_rst = 1'b0;

    // Randomised phase.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        #3 clk_rst = 1'b1;
        @(negedge clk);
        clk_rst = 1'b0;
      end else begin
        if ($urandom_range(0, 2) == 0) step_clk = ~step_clk;
        enable  = ($urandom_range(0, 9) != 0);
        restart = ($urandom_range(0, 149) == 0);
      end
    end
    @(negedge clk);
    restart = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
